// File: rtl/datapath_ctrl_if.sv
// Purpose: bundles the fetch handshake, datapath status and control outputs of datapath_ctrl.
// Latency: wires only, no storage.
// Backpressure: instReq is the ready side of the fetch handshake; an instruction moves only when instReq && instValid.
interface datapath_ctrl_if #(
    parameter int INST_W = 24
);
    logic              instValid;
    logic [INST_W-1:0] inst;
    logic              cero;
    logic              instReq;
    logic              regWrite;
    logic              aluSrc;
    logic              immSrc;
    logic              PCSrc;
    logic [1:0]        aluControl;
    logic              pcEn;
    logic [INST_W-1:0] irOut;
    logic              halted;
    logic              illegal;
    logic              fetchErr;
    logic [15:0]       retired;

    // Controller side: consumes fetch data and the zero flag, drives all controls.
    modport master (
        input  instValid, inst, cero,
        output instReq, regWrite, aluSrc, immSrc, PCSrc, aluControl,
               pcEn, irOut, halted, illegal, fetchErr, retired
    );

    // Memory/datapath side: supplies fetch data and the zero flag, observes controls.
    modport slave (
        output instValid, inst, cero,
        input  instReq, regWrite, aluSrc, immSrc, PCSrc, aluControl,
               pcEn, irOut, halted, illegal, fetchErr, retired
    );
endinterface

// File: rtl/datapath_ctrl.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 24-bit datapath; RETIRE_COUNT_EN enables the retired counter.
// Latency: accept to next instReq is 4 cycles; registered outputs, one cycle after the deciding edge.
// Backpressure: waits in FETCH with instReq high; pulses fetchErr after TIMEOUT idle cycles and keeps requesting.
module datapath_ctrl #(
    parameter int INST_W  = 24,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    datapath_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          wr_pend;   // decoded op writes the register file in WB
    logic          is_beq;    // decoded op is a conditional branch
    logic [3:0]    opcode;

    assign opcode = bus.irOut[INST_W-1 -: 4];

    // Main sequencer: state, fetch timer and every registered control output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_FETCH;
            timer          <= '0;
            wr_pend        <= 1'b0;
            is_beq         <= 1'b0;
            bus.instReq    <= 1'b0;
            bus.regWrite   <= 1'b0;
            bus.aluSrc     <= 1'b0;
            bus.immSrc     <= 1'b0;
            bus.PCSrc      <= 1'b0;
            bus.aluControl <= 2'b00;
            bus.pcEn       <= 1'b0;
            bus.irOut      <= '0;
            bus.halted     <= 1'b0;
            bus.illegal    <= 1'b0;
            bus.fetchErr   <= 1'b0;
        end else begin
            bus.fetchErr <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (bus.instReq && bus.instValid) begin
                        // Accept beats a coincident timeout.
                        bus.irOut   <= bus.inst;
                        bus.instReq <= 1'b0;
                        timer       <= '0;
                        state       <= S_DECODE;
                    end else if (bus.instReq) begin
                        if (timer == TW'(TIMEOUT)) begin
                            bus.fetchErr <= 1'b1;
                            timer        <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end else begin
                        // First FETCH after reset: raise the request.
                        bus.instReq <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state          <= S_EXEC;
                    bus.aluSrc     <= 1'b0;
                    bus.immSrc     <= 1'b0;
                    bus.aluControl <= 2'b00;
                    wr_pend        <= 1'b0;
                    is_beq         <= 1'b0;
                    case (opcode)
                        4'h0, 4'h1, 4'h2, 4'h3: begin
                            bus.aluControl <= opcode[1:0];
                            wr_pend        <= 1'b1;
                        end
                        4'h4, 4'h5: begin
                            bus.aluSrc     <= 1'b1;
                            bus.aluControl <= {1'b0, opcode[0]};
                            wr_pend        <= 1'b1;
                        end
                        4'h6: begin
                            bus.aluSrc <= 1'b1;
                            bus.immSrc <= 1'b1;
                            wr_pend    <= 1'b1;
                        end
                        4'h7: begin
                            bus.aluControl <= 2'b01;
                            is_beq         <= 1'b1;
                        end
                        4'h8: begin
                        end
                        4'hF: begin
                            state      <= S_HALT;
                            bus.halted <= 1'b1;
                        end
                        default: begin
                            bus.illegal <= 1'b1;
                        end
                    endcase
                end
                S_EXEC: begin
                    bus.PCSrc    <= is_beq & bus.cero;
                    bus.regWrite <= wr_pend;
                    bus.pcEn     <= 1'b1;
                    state        <= S_WB;
                end
                S_WB: begin
                    bus.regWrite <= 1'b0;
                    bus.pcEn     <= 1'b0;
                    bus.PCSrc    <= 1'b0;
                    bus.instReq  <= 1'b1;
                    state        <= S_FETCH;
                end
                S_HALT: begin
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

`ifdef RETIRE_COUNT_EN
    logic [15:0] retire_cnt;

    // One count per completed write-back; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= 16'h0000;
        end else if (state == S_WB) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end

    assign bus.retired = retire_cnt;
`else
    assign bus.retired = 16'h0000;
`endif
endmodule

// File: tb/tb_datapath_ctrl.sv
// Purpose: directed self-checking bench for datapath_ctrl with a per-cycle reference model.
// Latency: model advances on each rising edge; outputs compared on each falling edge.
// Backpressure: stimulus drives instValid only while the bench expects FETCH, except where ignore behaviour is exercised.
module tb_datapath_ctrl;
    localparam int TIMEOUT = 15;
`ifdef RETIRE_COUNT_EN
    localparam bit RET_ON = 1'b1;
`else
    localparam bit RET_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   check_en;

    datapath_ctrl_if #(.INST_W(24)) bus();

    datapath_ctrl #(.INST_W(24), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       wr;
        logic       src;
        logic       imm;
        logic [1:0] alu;
        logic       beq;
        logic       halt;
        logic       bad;
    } dec_t;

    function automatic dec_t decode_ref(input logic [3:0] op);
        dec_t d;
        d = '0;
        case (op)
            4'h0: begin d.wr = 1'b1; d.alu = 2'b00; end
            4'h1: begin d.wr = 1'b1; d.alu = 2'b01; end
            4'h2: begin d.wr = 1'b1; d.alu = 2'b10; end
            4'h3: begin d.wr = 1'b1; d.alu = 2'b11; end
            4'h4: begin d.wr = 1'b1; d.src = 1'b1; d.alu = 2'b00; end
            4'h5: begin d.wr = 1'b1; d.src = 1'b1; d.alu = 2'b01; end
            4'h6: begin d.wr = 1'b1; d.src = 1'b1; d.imm = 1'b1; end
            4'h7: begin d.beq = 1'b1; d.alu = 2'b01; end
            4'h8: begin end
            4'hF: begin d.halt = 1'b1; end
            default: begin d.bad = 1'b1; end
        endcase
        return d;
    endfunction

    int          since;    // 0 = fetching, 1..3 = cycles since accept
    bit          req_up;
    int          waited;
    bit          hlt;
    int          ret;
    dec_t        cur;
    bit          taken;
    logic [23:0] e_ir;
    bit          e_ill;
    bit          e_ferr;

    always @(posedge clk) begin
        if (!rst) begin
            since = 0; req_up = 1'b0; waited = 0; hlt = 1'b0; ret = 0;
            cur = '0; taken = 1'b0; e_ir = '0; e_ill = 1'b0; e_ferr = 1'b0;
        end else begin
            e_ferr = 1'b0;
            if (hlt) begin
            end else if (since == 0) begin
                if (!req_up) begin
                    req_up = 1'b1;
                end else if (bus.instValid) begin
                    e_ir = bus.inst; since = 1; req_up = 1'b0; waited = 0;
                end else begin
                    waited++;
                    if (waited == TIMEOUT + 1) begin
                        e_ferr = 1'b1; waited = 0;
                    end
                end
            end else if (since == 1) begin
                cur = decode_ref(e_ir[23:20]);
                taken = 1'b0;
                if (cur.bad) e_ill = 1'b1;
                if (cur.halt) begin hlt = 1'b1; since = 0; end
                else since = 2;
            end else if (since == 2) begin
                taken = cur.beq & bus.cero;
                since = 3;
            end else begin
                since = 0; req_up = 1'b1; ret++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_instReq",  32'(bus.instReq),  32'(req_up && since == 0 && !hlt));
            chk("m_regWrite", 32'(bus.regWrite), 32'(since == 3 && cur.wr));
            chk("m_pcEn",     32'(bus.pcEn),     32'(since == 3));
            chk("m_PCSrc",    32'(bus.PCSrc),    32'(since == 3 && taken));
            chk("m_aluSrc",   32'(bus.aluSrc),   32'(cur.src));
            chk("m_immSrc",   32'(bus.immSrc),   32'(cur.imm));
            chk("m_aluCtl",   32'(bus.aluControl), 32'(cur.alu));
            chk("m_irOut",    32'(bus.irOut),    32'(e_ir));
            chk("m_halted",   32'(bus.halted),   32'(hlt));
            chk("m_illegal",  32'(bus.illegal),  32'(e_ill));
            chk("m_fetchErr", 32'(bus.fetchErr), 32'(e_ferr));
            chk("m_retired",  32'(bus.retired),  RET_ON ? 32'(ret & 32'hFFFF) : 32'h0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Starts in a FETCH cycle with instReq high; ends in the next FETCH cycle.
    task automatic issue_chk(input string nm, input logic [23:0] w, input logic z, input bit hold,
                             input logic x_wr, input logic x_src, input logic x_imm,
                             input logic [1:0] x_alu, input logic x_pcsrc);
        bus.instValid = 1'b1; bus.inst = w;
        tick();                                    // DECODE
        chk({nm, "_dec_req"}, 32'(bus.instReq), 32'd0);
        chk({nm, "_dec_ir"},  32'(bus.irOut), 32'(w));
        if (!hold) bus.instValid = 1'b0;
        tick();                                    // EXEC
        chk({nm, "_ex_wr"},  32'(bus.regWrite), 32'd0);
        chk({nm, "_ex_src"}, 32'(bus.aluSrc), 32'(x_src));
        chk({nm, "_ex_imm"}, 32'(bus.immSrc), 32'(x_imm));
        chk({nm, "_ex_alu"}, 32'(bus.aluControl), 32'(x_alu));
        bus.cero = z;
        tick();                                    // WB
        bus.cero = 1'b0;
        chk({nm, "_wb_wr"},  32'(bus.regWrite), 32'(x_wr));
        chk({nm, "_wb_pc"},  32'(bus.pcEn), 32'd1);
        chk({nm, "_wb_psrc"}, 32'(bus.PCSrc), 32'(x_pcsrc));
        chk({nm, "_wb_src"}, 32'(bus.aluSrc), 32'(x_src));
        chk({nm, "_wb_alu"}, 32'(bus.aluControl), 32'(x_alu));
        tick();                                    // FETCH
        bus.instValid = 1'b0;
        chk({nm, "_f_req"}, 32'(bus.instReq), 32'd1);
        chk({nm, "_f_wr"},  32'(bus.regWrite), 32'd0);
        chk({nm, "_f_pc"},  32'(bus.pcEn), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100000");
        $fatal(1, "bench stalled");
    end

    initial begin
        total = 0; bad = 0; check_en = 1'b0;
        rst = 1'b0; bus.instValid = 1'b0; bus.inst = '0; bus.cero = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(bus.instReq), 32'd0);
        chk("rst_ir",  32'(bus.irOut), 32'd0);
        chk("rst_halt", 32'(bus.halted), 32'd0);
        chk("rst_ret", 32'(bus.retired), 32'd0);
        rst = 1'b1; check_en = 1'b1;
        tick();                                    // cycle 0: request up
        chk("c0_req", 32'(bus.instReq), 32'd1);

        // ADD with instValid held high through the instruction.
        issue_chk("add", 24'h012300, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        // SUBI imm 0x00A.
        issue_chk("subi", 24'h50000A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        // BEQ taken / not taken.
        issue_chk("beq1", 24'h712000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        issue_chk("beq0", 24'h712000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        // OR, AND.
        issue_chk("or",  24'h345000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
        issue_chk("and", 24'h245000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);

        // Valid on the 16th waiting cycle: accept wins, no fetchErr.
        for (int i = 1; i < 16; i++) tick();
        bus.instValid = 1'b1; bus.inst = 24'h800000;
        tick();
        bus.instValid = 1'b0;
        chk("race_ferr", 32'(bus.fetchErr), 32'd0);
        chk("race_req",  32'(bus.instReq), 32'd0);
        tick(); tick(); tick();

        // 16 idle cycles: one fetchErr pulse, request kept up.
        for (int i = 1; i <= 16; i++) begin
            chk("to_quiet", 32'(bus.fetchErr), 32'd0);
            tick();
        end
        chk("to_ferr", 32'(bus.fetchErr), 32'd1);
        chk("to_req",  32'(bus.instReq), 32'd1);
        issue_chk("addis", 24'h600005, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);

        // Illegal opcode is sticky and behaves as NOP.
        issue_chk("ill", 24'hA00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("ill_set", 32'(bus.illegal), 32'd1);
        issue_chk("add2", 24'h012300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("ill_sticky", 32'(bus.illegal), 32'd1);

        // HALT: no further requests even with instValid asserted.
        bus.instValid = 1'b1; bus.inst = 24'hF00000;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            chk("halt_flag", 32'(bus.halted), 32'd1);
            chk("halt_req",  32'(bus.instReq), 32'd0);
            tick();
        end
        rst = 1'b0; bus.instValid = 1'b0;
        #1;
        chk("hrst_halt", 32'(bus.halted), 32'd0);
        chk("hrst_ill",  32'(bus.illegal), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("hrst_req", 32'(bus.instReq), 32'd1);

        // Reset during EXEC of an ADD aborts it.
        bus.instValid = 1'b1; bus.inst = 24'h012300;
        tick();
        bus.instValid = 1'b0;
        tick();                                    // EXEC
        rst = 1'b0;
        #1;
        chk("xrst_wr",  32'(bus.regWrite), 32'd0);
        chk("xrst_pc",  32'(bus.pcEn), 32'd0);
        chk("xrst_req", 32'(bus.instReq), 32'd0);
        chk("xrst_ir",  32'(bus.irOut), 32'd0);
        tick();
        chk("xrst_wr2", 32'(bus.regWrite), 32'd0);
        chk("xrst_pc2", 32'(bus.pcEn), 32'd0);
        rst = 1'b1;
        tick();

        // Three retirements after reset.
        issue_chk("r1", 24'h112300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        issue_chk("r2", 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        issue_chk("r3", 24'h712000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        chk("retired3", 32'(bus.retired), RET_ON ? 32'd3 : 32'd0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Multi-cycle control FSM that sequences the 24-bit single-issue datapath: fetch, decode, execute, write-back.
- Fetches instructions over a valid/ready handshake and decodes opcode inst[23:20].
- Drives regWrite, aluSrc, PCSrc, immSrc, aluControl and a PC-advance enable.
- Samples the ALU zero flag (cero) for conditional branches.

Parameters:
- INST_W, 24, instruction width; opcode is always the top 4 bits.
- TIMEOUT, 15, max wait cycles in FETCH before fetchErr pulses and the request restarts.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instValid  in  1  instruction memory has data on inst.
- inst  in  INST_W  instruction word, sampled when instReq&&instValid.
- cero  in  1  ALU zero flag from datapath.
- instReq  out  1  fetch request (ready).
- regWrite  out  1  register file write enable.
- aluSrc  out  1  0=rd2, 1=extended immediate.
- immSrc  out  1  immediate extension mode.
- PCSrc  out  1  1=branch target selected.
- aluControl  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- pcEn  out  1  one-cycle PC update strobe.
- irOut  out  INST_W  latched instruction register, drives datapath inst.
- halted  out  1  HALT executed.
- illegal  out  1  sticky: undefined opcode seen.
- fetchErr  out  1  one-cycle pulse on fetch timeout.
- retired  out  16  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (rst=0, async): state=FETCH; irOut=0. All of the following are 0: instReq, regWrite, aluSrc, immSrc, PCSrc, aluControl, pcEn, halted, illegal, fetchErr, retired, timeout counter. Outputs are registered.
- States: FETCH, DECODE, EXEC, WB, HALT.
- FETCH:
  - instReq=1.
  - On instValid=1: latch inst into irOut, clear timer, go to DECODE.
  - Otherwise the timer increments. At timer==TIMEOUT: pulse fetchErr, clear timer, stay in FETCH.
- DECODE (1 cycle): instReq=0. Decode irOut[23:20] and register the control values, which are held stable through EXEC and WB:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR: aluSrc=0, regWrite pending.
  - 0100 ADDI, 0101 SUBI: aluSrc=1, immSrc=0, regWrite pending.
  - 0110 ADDIS: aluSrc=1, immSrc=1, aluControl=00, regWrite pending.
  - 0111 BEQ: aluControl=01, aluSrc=0, no write.
  - 1000 NOP: no write, no branch.
  - 1111 HALT: go to HALT.
  - Any other opcode: set illegal, treat as NOP.
- EXEC (1 cycle): datapath computes. For BEQ, cero is sampled at the end of EXEC and PCSrc=cero is registered.
- WB (1 cycle):
  - regWrite=1 only for write-pending opcodes.
  - pcEn=1 for every non-HALT instruction, with PCSrc as registered.
  - retired increments.
  - Next state FETCH. On exit, regWrite, pcEn and PCSrc return to 0.
- HALT: halted=1; no requests. Exit only by reset.
- Throughput: accept-to-next-instReq is exactly 4 cycles (DECODE, EXEC, WB, FETCH).
- instValid outside FETCH is ignored.
- instValid on the same cycle as timeout: the accept wins, and fetchErr is not pulsed.
- Reset mid-instruction aborts it, with no regWrite or pcEn issued.
- retired wraps 0xFFFF→0x0000.

Optional Feature:
- Macro RETIRE_COUNT_EN.
- Defined: retired is a 16-bit counter, incremented once per WB.
- Undefined: retired is tied to 16'h0000 and no counter flops are synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- ADD (inst=24'h012300), instValid held high → instReq at cycle 0, DECODE at 1, EXEC at 2. At cycle 3 (WB): regWrite=1, aluControl=00, aluSrc=0, pcEn=1, PCSrc=0. instReq=1 again at cycle 4.
- SUBI (opcode 0101, imm=0x00A) → aluSrc=1, immSrc=0, aluControl=01 held through EXEC and WB; regWrite=1 in WB only.
- BEQ with cero=1 in EXEC → WB has pcEn=1, PCSrc=1, regWrite=0. Repeat with cero=0 → PCSrc=0.
- instValid held low for 16 cycles → fetchErr pulses exactly once at the 16th cycle, and instReq stays 1. Assert instValid on cycle 17 → accepted, DECODE next.
- Opcode 1010 → illegal=1 (remains 1 after later valid instructions), no regWrite. Then HALT (1111) → halted=1, instReq=0 forever; rst=0 pulse clears halted and illegal and returns to FETCH.
- rst asserted during EXEC of an ADD → outputs 0 immediately (asynchronously), no regWrite pulse. With RETIRE_COUNT_EN, 3 retired instructions → retired=3; without the macro → retired=0.
